input_conditioner: RTL and testbench
====================================

Name: input_conditioner

Overview:
- Upstream stage for the sequence-detector FSM pair.
- Synchronizes and debounces the raw slide switch and the step push-button.
- Delivers a clean level `w_out` and a single-cycle `step` enable, so both FSMs advance exactly once per physical button press on the board clock.
- Also keeps a 4-bit press counter for LED/debug display.

Parameters:
- DEBOUNCE_CYCLES, 1000000, consecutive synchronized samples required to accept a new input level (10 ms at 100 MHz); legal range >= 2.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1), width of each debounce counter (derived; not overridden).

Ports:
- clk  input  1  board clock; all state updates on its rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state immediately when 0.
- btn_raw  input  1  raw, bouncy, asynchronous step push-button.
- sw_raw  input  1  raw, bouncy, asynchronous slide switch (FSM input w).
- w_out  output  1  debounced switch level.
- btn_level  output  1  debounced button level.
- step  output  1  one-cycle pulse on each accepted button press; used as the FSM clock enable.
- press_count  output  4  number of accepted presses, modulo 16.

Behaviour:
- Reset (reset=0, async):
  - Synchronizer flops = 0.
  - Both debounce FSMs in STABLE_LO with counters = 0.
  - w_out = 0, btn_level = 0, step = 0, press_count = 0.
  - Outputs stay at these values while reset is held. Reset release is sampled normally; no output changes on the release edge itself.
- Synchronizer: a two-flop chain per raw input produces s_btn and s_sw. There is no combinational path from raw inputs to outputs.
- Debounce FSM (one instance per input, identical). States STABLE_LO, WAIT_HI, STABLE_HI, WAIT_LO; cnt is the per-instance counter.
  - STABLE_LO: s=1 -> WAIT_HI, cnt=1; else stay.
  - WAIT_HI: s=0 -> STABLE_LO, cnt=0 (bounce rejected); s=1 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_HI, cnt=0; else cnt+1.
  - STABLE_HI: s=0 -> WAIT_LO, cnt=1; else stay.
  - WAIT_LO: mirror of WAIT_HI (s=1 -> STABLE_HI; s=0 and cnt==DEBOUNCE_CYCLES-1 -> STABLE_LO).
- Level output:
  - Level output = 1 in STABLE_HI and WAIT_LO; = 0 in STABLE_LO and WAIT_HI.
  - Level outputs are registered.
- Latency: raw level stable from before edge k -> level output changes on edge k+DEBOUNCE_CYCLES+1.
- Glitch rejection: any glitch shorter than DEBOUNCE_CYCLES synchronized samples never reaches the outputs.
- step:
  - Registered; high for exactly one cycle, rising on the same edge on which btn_level goes 0->1 (WAIT_HI -> STABLE_HI).
  - Never asserted on release (1->0).
  - A held button produces one step only.
  - Minimum spacing between steps is 2*DEBOUNCE_CYCLES cycles.
- press_count:
  - Increments by 1 on the edge after step is high, i.e. it reflects the press one cycle after step.
  - Wraps 15 -> 0 with no flag.
- Switch and button paths are fully independent:
  - Simultaneous changes on both are each processed on their own schedule.
  - The consuming FSM samples w_out on the edge where step=1; the value seen is whatever w_out holds in that cycle.
- Reset mid-operation (any state, any cnt):
  - Immediate return to reset values.
  - A pending press in WAIT_HI is discarded and does not produce step after release.

Test Plan:
- T1 reset: DEBOUNCE_CYCLES=4; assert reset=0 mid-cycle -> all outputs 0 immediately, before the next clk edge; hold reset=0 for 3 cycles -> outputs remain 0.
- T2 clean press: btn_raw 0->1 before edge k, held for 20 cycles -> btn_level=1 and step=1 at edge k+5; step=0 at k+6; press_count=1 at k+6; no further step while held.
- T3 bounce: btn_raw toggles every 2 cycles for 12 cycles, then is held at 1 -> zero steps during toggling; exactly one step at hold-start edge +5; release with bounce -> btn_level falls once, no step.
- T4 switch: sw_raw 0->1 with 3-cycle glitches, then held -> w_out rises exactly once, 5 edges after the final stable transition; step stays 0 throughout.
- T5 wrap: 17 clean presses spaced 20 cycles apart -> press_count sequence 1..15, 0, 1; exactly 17 step pulses.
- T6 reset mid-press: btn held for 2 synchronized cycles (WAIT_HI), then reset pulsed low, then button held -> no step from the aborted press; a fresh step comes DEBOUNCE_CYCLES+1 edges after reset release with btn high; press_count=1.

Source files
------------

// File: rtl/input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : input_conditioner
// Brief    : Two-flop synchronizers and debounce FSMs for a step button and a
//            slide switch; emits a one-cycle step pulse and a press counter.
// Revision : 1.0 - initial release
// ============================================================================

module input_conditioner_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic i_sync,
  output logic o_level,
  output logic o_rise
);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    WAIT_HI   = 2'd1,
    STABLE_HI = 2'd2,
    WAIT_LO   = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_level;
  logic             r_rise;
  logic             w_done;

  assign w_done = (r_cnt == c_LAST_CNT);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      STABLE_LO: begin
        if (i_sync) begin
          w_state_nxt = WAIT_HI;
          w_cnt_nxt   = c_ONE;
        end
      end
      WAIT_HI: begin
        if (!i_sync) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else if (w_done) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
        end
      end
      STABLE_HI: begin
        if (!i_sync) begin
          w_state_nxt = WAIT_LO;
          w_cnt_nxt   = c_ONE;
        end
      end
      WAIT_LO: begin
        if (i_sync) begin
          w_state_nxt = STABLE_HI;
          w_cnt_nxt   = '0;
        end else if (w_done) begin
          w_state_nxt = STABLE_LO;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt   = r_cnt + c_ONE;
        end
      end
      default: begin
        w_state_nxt = STABLE_LO;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Level and rise flags are registered from the next-state decode so they
  // switch on the same edge as the state that defines them.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= STABLE_LO;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_level <= (w_state_nxt == STABLE_HI) || (w_state_nxt == WAIT_LO);
      r_rise  <= (r_state == WAIT_HI) && (w_state_nxt == STABLE_HI);
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;

endmodule

module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_raw,
  input  logic       sw_raw,
  output logic       w_out,
  output logic       btn_level,
  output logic       step,
  output logic [3:0] press_count
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic       r_btn_meta;
  logic       r_btn_sync;
  logic       r_sw_meta;
  logic       r_sw_sync;
  logic       w_btn_rise;
  logic [3:0] r_press_count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_btn_meta <= 1'b0;
      r_btn_sync <= 1'b0;
      r_sw_meta  <= 1'b0;
      r_sw_sync  <= 1'b0;
    end else begin
      r_btn_meta <= btn_raw;
      r_btn_sync <= r_btn_meta;
      r_sw_meta  <= sw_raw;
      r_sw_sync  <= r_sw_meta;
    end
  end

  input_conditioner_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_btn_db (
    .clk     (clk),
    .reset   (reset),
    .i_sync  (r_btn_sync),
    .o_level (btn_level),
    .o_rise  (w_btn_rise)
  );

  input_conditioner_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_sw_db (
    .clk     (clk),
    .reset   (reset),
    .i_sync  (r_sw_sync),
    .o_level (w_out),
    .o_rise  ()
  );

  // Counter trails step by one edge; wraps silently.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_press_count <= 4'd0;
    end else if (w_btn_rise) begin
      r_press_count <= r_press_count + 4'd1;
    end
  end

  assign step        = w_btn_rise;
  assign press_count = r_press_count;

endmodule
`default_nettype wire

// File: tb/tb_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tb_input_conditioner
// Brief    : Self-checking bench for input_conditioner with a sample-window
//            reference model (D=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_input_conditioner;

  localparam int D = 4;

  logic       clk;
  logic       reset;
  logic       btn_raw;
  logic       sw_raw;
  logic       w_out;
  logic       btn_level;
  logic       step;
  logic [3:0] press_count;

  int n_checks = 0;
  int n_fail   = 0;

  input_conditioner #(.DEBOUNCE_CYCLES(D)) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_raw     (btn_raw),
    .sw_raw      (sw_raw),
    .w_out       (w_out),
    .btn_level   (btn_level),
    .step        (step),
    .press_count (press_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: the debouncer sees each raw value two edges late, and a
  // level flips once the last D seen samples all disagree with it.
  bit         m_d1 [2];
  bit         m_d2 [2];
  bit         m_lvl [2];
  logic [D-1:0] m_hist [2];
  bit         m_step;
  int         m_cnt;

  function automatic void model_reset();
    for (int ch = 0; ch < 2; ch++) begin
      m_d1[ch] = 0; m_d2[ch] = 0; m_lvl[ch] = 0; m_hist[ch] = '0;
    end
    m_step = 0;
    m_cnt  = 0;
  endfunction

  function automatic void model_edge(bit b, bit s);
    bit raw [2];
    raw[0] = b;
    raw[1] = s;
    if (m_step) m_cnt = (m_cnt + 1) % 16;
    m_step = 0;
    for (int ch = 0; ch < 2; ch++) begin
      m_hist[ch] = {m_hist[ch][D-2:0], m_d2[ch]};
      m_d2[ch]   = m_d1[ch];
      m_d1[ch]   = raw[ch];
      if (m_hist[ch] == {D{~m_lvl[ch]}}) begin
        m_lvl[ch] = ~m_lvl[ch];
        if (ch == 0 && m_lvl[ch]) m_step = 1;
      end
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    if (reset) model_edge(btn_raw, sw_raw);
    else       model_reset();
    #1;
  endtask

  task automatic test_reset();
    btn_raw = 0; sw_raw = 0; reset = 0;
    model_reset();
    repeat (3) tick();
    #1 reset = 1;
    repeat (2) tick();
    btn_raw = 1; sw_raw = 1;
    for (int i = 0; i < 12; i++) begin
      tick();
      n_checks++;
      if ({w_out, btn_level, step, press_count} !== {m_lvl[1], m_lvl[0], m_step, 4'(m_cnt)}) begin
        n_fail++;
        $display("FAIL reset_prefill cyc %0d: got %b%b%b %0d expected %b%b%b %0d", i, w_out, btn_level, step, press_count, m_lvl[1], m_lvl[0], m_step, m_cnt);
      end
    end
    #1 reset = 0;
    #1;
    n_checks++;
    if ({w_out, btn_level, step, press_count} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_async: got %b%b%b %0d expected 000 0", w_out, btn_level, step, press_count);
    end
    model_reset();
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if ({w_out, btn_level, step, press_count} !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_hold cyc %0d: got %b%b%b %0d expected 000 0", i, w_out, btn_level, step, press_count);
      end
    end
    btn_raw = 0; sw_raw = 0;
    #1 reset = 1;
    tick();
    n_checks++;
    if ({w_out, btn_level, step, press_count} !== 7'd0) begin
      n_fail++;
      $display("FAIL reset_release: got %b%b%b %0d expected 000 0", w_out, btn_level, step, press_count);
    end
  endtask

  task automatic test_clean_press();
    int c0;
    btn_raw = 0; sw_raw = 0;
    repeat (12) tick();
    c0 = m_cnt;
    btn_raw = 1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_checks++;
      if ({w_out, btn_level, step, press_count} !== {m_lvl[1], m_lvl[0], m_step, 4'(m_cnt)}) begin
        n_fail++;
        $display("FAIL clean_model cyc %0d: got %b%b%b %0d expected %b%b%b %0d", i, w_out, btn_level, step, press_count, m_lvl[1], m_lvl[0], m_step, m_cnt);
      end
      n_checks++;
      if (step !== (i == 6) || btn_level !== (i >= 6)) begin
        n_fail++;
        $display("FAIL clean_timing edge k+%0d: got step=%b lvl=%b expected step=%b lvl=%b", i - 1, step, btn_level, (i == 6), (i >= 6));
      end
      if (i == 7) begin
        n_checks++;
        if (press_count !== 4'(c0 + 1)) begin
          n_fail++;
          $display("FAIL clean_count: got %0d expected %0d", press_count, c0 + 1);
        end
      end
    end
    btn_raw = 0;
    repeat (10) tick();
  endtask

  task automatic test_bounce();
    int steps;
    int falls;
    bit prev_lvl;
    steps = 0;
    for (int i = 0; i < 12; i++) begin
      btn_raw = ((i >> 1) & 1) == 0;
      tick();
      if (step) steps++;
    end
    n_checks++;
    if (steps != 0) begin
      n_fail++;
      $display("FAIL bounce_press: got %0d steps expected 0", steps);
    end
    btn_raw = 1;
    for (int j = 1; j <= 15; j++) begin
      tick();
      if (step) steps++;
      n_checks++;
      if (step !== (j == 6) || step !== m_step) begin
        n_fail++;
        $display("FAIL bounce_hold edge +%0d: got step=%b expected %b", j - 1, step, (j == 6));
      end
    end
    falls = 0;
    prev_lvl = btn_level;
    for (int i = 0; i < 20; i++) begin
      btn_raw = (i < 8) ? (((i >> 1) & 1) == 1) : 1'b0;
      tick();
      if (step) steps++;
      if (prev_lvl && !btn_level) falls++;
      prev_lvl = btn_level;
      n_checks++;
      if ({w_out, btn_level, step, press_count} !== {m_lvl[1], m_lvl[0], m_step, 4'(m_cnt)}) begin
        n_fail++;
        $display("FAIL bounce_release cyc %0d: got %b%b%b %0d expected %b%b%b %0d", i, w_out, btn_level, step, press_count, m_lvl[1], m_lvl[0], m_step, m_cnt);
      end
    end
    n_checks++;
    if (falls != 1 || steps != 1) begin
      n_fail++;
      $display("FAIL bounce_totals: got falls=%0d steps=%0d expected falls=1 steps=1", falls, steps);
    end
  endtask

  task automatic test_switch();
    int rises;
    int steps;
    bit prev;
    rises = 0; steps = 0;
    btn_raw = 0;
    prev = w_out;
    for (int i = 0; i < 18; i++) begin
      sw_raw = (i % 6) < 3;
      tick();
      if (!prev && w_out) rises++;
      if (step) steps++;
      prev = w_out;
    end
    sw_raw = 1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (!prev && w_out) rises++;
      if (step) steps++;
      prev = w_out;
      n_checks++;
      if (w_out !== (j >= 6) || w_out !== m_lvl[1]) begin
        n_fail++;
        $display("FAIL switch_level edge +%0d: got %b expected %b", j - 1, w_out, (j >= 6));
      end
    end
    n_checks++;
    if (rises != 1 || steps != 0) begin
      n_fail++;
      $display("FAIL switch_totals: got rises=%0d steps=%0d expected rises=1 steps=0", rises, steps);
    end
    sw_raw = 0;
    repeat (10) tick();
  endtask

  task automatic test_wrap();
    int steps;
    bit prev_step;
    btn_raw = 0; sw_raw = 0;
    #1 reset = 0;
    repeat (2) tick();
    #1 reset = 1;
    steps = 0;
    prev_step = 0;
    for (int p = 0; p < 17; p++) begin
      for (int c = 0; c < 20; c++) begin
        btn_raw = (c < 10);
        tick();
        if (prev_step) begin
          n_checks++;
          if (press_count !== 4'((steps) % 16)) begin
            n_fail++;
            $display("FAIL wrap_count press %0d: got %0d expected %0d", steps, press_count, steps % 16);
          end
        end
        if (step) steps++;
        prev_step = step;
        n_checks++;
        if ({w_out, btn_level, step, press_count} !== {m_lvl[1], m_lvl[0], m_step, 4'(m_cnt)}) begin
          n_fail++;
          $display("FAIL wrap_model p%0d c%0d: got %b%b%b %0d expected %b%b%b %0d", p, c, w_out, btn_level, step, press_count, m_lvl[1], m_lvl[0], m_step, m_cnt);
        end
      end
    end
    n_checks++;
    if (steps != 17 || press_count !== 4'd1) begin
      n_fail++;
      $display("FAIL wrap_totals: got steps=%0d count=%0d expected steps=17 count=1", steps, press_count);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) btn_raw = ~btn_raw;
      if ($urandom_range(0, 5) == 0) sw_raw = ~sw_raw;
      tick();
      n_checks++;
      if ({w_out, btn_level, step, press_count} !== {m_lvl[1], m_lvl[0], m_step, 4'(m_cnt)}) begin
        n_fail++;
        $display("FAIL random cyc %0d: got %b%b%b %0d expected %b%b%b %0d", i, w_out, btn_level, step, press_count, m_lvl[1], m_lvl[0], m_step, m_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    int steps;
    btn_raw = 0; sw_raw = 0;
    repeat (12) tick();
    steps = 0;
    btn_raw = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (step) steps++;
    end
    #1 reset = 0;
    repeat (2) tick();
    #1 reset = 1;
    for (int j = 1; j <= 12; j++) begin
      tick();
      if (step) steps++;
      n_checks++;
      if ({w_out, btn_level, step, press_count} !== {m_lvl[1], m_lvl[0], m_step, 4'(m_cnt)}) begin
        n_fail++;
        $display("FAIL midreset_model edge %0d: got %b%b%b %0d expected %b%b%b %0d", j, w_out, btn_level, step, press_count, m_lvl[1], m_lvl[0], m_step, m_cnt);
      end
    end
    n_checks++;
    if (steps != 1 || press_count !== 4'd1) begin
      n_fail++;
      $display("FAIL midreset_totals: got steps=%0d count=%0d expected steps=1 count=1", steps, press_count);
    end
    btn_raw = 0;
    repeat (10) tick();
  endtask

  initial begin
    reset = 0; btn_raw = 0; sw_raw = 0;
    test_reset();
    test_clean_press();
    test_bounce();
    test_switch();
    test_wrap();
    test_reset_mid_press();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
